// File: rtl/dac_serial_receiver_pkg.sv
// Shared definitions for the DAC serial link receiver.
// Holds the default frame geometry, the power-down field position and the
// receiver state encoding. The transmitter uses the same field positions.
package dac_serial_receiver_pkg;

    localparam int FRAME_BITS_DEF  = 16;
    localparam int DATA_BITS_DEF   = 12;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_BITS_DEF    = 16;

    // Power-down field occupies frame bits 13..12.
    localparam int PD_LSB  = 12;
    localparam int PD_BITS = 2;

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/dac_serial_receiver_if.sv
// Bus bundle for the DAC serial receiver.
// Serial side : sclk, sync (active-low frame strobe), din.
// Output side : data_out, pd_out, valid/frame_err pulses, busy, frame_cnt,
//               plus the receiver FSM state for observation.
// Handshake   : valid and frame_err are single-cycle strobes with no back
//               pressure; data_out/pd_out/frame_cnt are stable from the cycle
//               valid is high until the next valid. The serial wires carry no
//               handshake and are oversampled asynchronously.
interface dac_serial_receiver_if #(
    parameter int DATA_BITS = 12,
    parameter int CNT_BITS  = 16
);
    import dac_serial_receiver_pkg::*;

    logic                 sclk;
    logic                 sync;
    logic                 din;
    logic [DATA_BITS-1:0] data_out;
    logic [PD_BITS-1:0]   pd_out;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;
    logic [CNT_BITS-1:0]  frame_cnt;
    rx_state_e            state;

    // Transmitter / consumer side.
    modport master (
        output sclk, sync, din,
        input  data_out, pd_out, valid, frame_err, busy, frame_cnt, state
    );

    // Receiver side.
    modport slave (
        input  sclk, sync, din,
        output data_out, pd_out, valid, frame_err, busy, frame_cnt, state
    );

endinterface

// File: rtl/dac_serial_receiver_sync_edge_det.sv
// Multi-flop synchronizer with a registered-history edge detector.
// Ports:
//   clk_i, rst_i : system clock, async active-high reset
//   d_i          : asynchronous input wire
//   q_o          : synchronized level (last synchronizer stage)
//   rise_o       : high for one clk when q_o went 0 -> 1
//   fall_o       : high for one clk when q_o went 1 -> 0
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    // Compare against the previous synchronized sample held in prev_q.
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/dac_serial_receiver.sv
// Receiver for the 3-wire DAC serial link (sync, sclk, din).
// Oversamples the wires on clk, deframes FRAME_BITS-bit MSB-first words and
// presents the sample and power-down field with a one-cycle valid strobe.
// Aborted frames (sync rising early) give a one-cycle frame_err strobe.
// Ports:
//   clk, rst : system clock (>= 4x sclk), async active-high reset
//   bus      : slave modport carrying the serial wires and all outputs
module dac_serial_receiver
    import dac_serial_receiver_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int DATA_BITS   = DATA_BITS_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_BITS    = CNT_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    dac_serial_receiver_if.slave  bus
);

    localparam int BCW = $clog2(FRAME_BITS + 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic sync_lvl, sync_rise, sync_fall;
    logic din_lvl;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sclk_det (
        .clk_i  (clk),
        .rst_i  (rst),
        .d_i    (bus.sclk),
        .q_o    (sclk_lvl),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_det (
        .clk_i  (clk),
        .rst_i  (rst),
        .d_i    (bus.sync),
        .q_o    (sync_lvl),
        .rise_o (sync_rise),
        .fall_o (sync_fall)
    );

    // din gets the same depth as sclk so its sampled value lines up with
    // the detected sclk fall.
    logic [SYNC_STAGES-1:0] din_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_sync_q <= '0;
        end else begin
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], bus.din};
        end
    end

    assign din_lvl = din_sync_q[SYNC_STAGES-1];

    rx_state_e             state_q;
    logic [BCW-1:0]        bit_cnt_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0]  data_q;
    logic [PD_BITS-1:0]    pd_q;
    logic                  valid_q;
    logic                  err_q;
    logic [CNT_BITS-1:0]   cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ARM;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            pd_q      <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                // A sync already low at reset release must not start a frame.
                ST_ARM: begin
                    if (sync_lvl) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (sync_fall) begin
                        bit_cnt_q <= '0;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt_q == BCW'(FRAME_BITS)) begin
                        valid_q <= 1'b1;
                        data_q  <= shift_q[DATA_BITS-1:0];
                        pd_q    <= shift_q[PD_LSB +: PD_BITS];
                        cnt_q   <= cnt_q + 1'b1;
                        // A sync rise landing on the commit cycle still closes
                        // the frame, so skip HOLD rather than wait for another.
                        state_q <= sync_rise ? ST_IDLE : ST_HOLD;
                    end else if (sync_rise) begin
                        // Checked before sclk_fall: a rise coinciding with the
                        // last fall aborts the frame.
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (sclk_fall) begin
                        shift_q   <= {shift_q[FRAME_BITS-2:0], din_lvl};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Surplus sclk falls are ignored here.
                    if (sync_rise) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_ARM;
            endcase
        end
    end

    assign bus.data_out  = data_q;
    assign bus.pd_out    = pd_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = (state_q == ST_SHIFT);
    assign bus.frame_cnt = cnt_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_dac_serial_receiver.sv
module tb_dac_serial_receiver;

    localparam int W = 30; // {frame_cnt[15:0], pd[1:0], data[11:0]}

    logic clk;
    logic rst;
    logic sclk;
    logic sync;
    logic din;

    int checks;
    int errors;

    logic [W-1:0] exp_q[$];
    logic [15:0]  exp_cnt;
    logic [11:0]  last_data;
    logic [1:0]   last_pd;
    int           err_exp;
    int           err_seen;
    int           valid_seen;

    dac_serial_receiver_if #(.DATA_BITS(12), .CNT_BITS(16)) bus ();
    dac_serial_receiver_if #(.DATA_BITS(12), .CNT_BITS(3))  bus2 ();

    assign bus.sclk  = sclk;
    assign bus.sync  = sync;
    assign bus.din   = din;
    assign bus2.sclk = sclk;
    assign bus2.sync = sync;
    assign bus2.din  = din;

    dac_serial_receiver #(.CNT_BITS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Narrow-counter instance to exercise the wrap without thousands of frames.
    dac_serial_receiver #(.CNT_BITS(3)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid) begin
                valid_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid got data=%h pd=%b cnt=%0d, no frame expected",
                             bus.data_out, bus.pd_out, bus.frame_cnt);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if ({bus.frame_cnt, bus.pd_out, bus.data_out} !== e) begin
                        errors++;
                        $display("FAIL frame_out got cnt=%0d pd=%b data=%h exp cnt=%0d pd=%b data=%h",
                                 bus.frame_cnt, bus.pd_out, bus.data_out, e[29:14], e[13:12], e[11:0]);
                    end
                    checks++;
                    if (!bus2.valid || bus2.frame_cnt !== e[16:14]) begin
                        errors++;
                        $display("FAIL wrap_cnt got valid=%b cnt=%0d exp valid=1 cnt=%0d",
                                 bus2.valid, bus2.frame_cnt, e[16:14]);
                    end
                end
            end
            if (bus.frame_err) err_seen++;
        end
    end

    // ---------------- reference model ----------------
    // A frame commits iff at least 16 sclk falls happen before sync rises.
    task automatic model_frame(input logic [15:0] w, input int nfalls);
        if (nfalls >= 16) begin
            exp_cnt   = exp_cnt + 16'd1;
            last_data = w[11:0];
            last_pd   = w[13:12];
            exp_q.push_back({exp_cnt, w[13:12], w[11:0]});
        end else begin
            err_exp++;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_cnt   = '0;
        last_data = '0;
        last_pd   = '0;
    endtask

    // ---------------- drivers ----------------
    task automatic drive_bit(input logic b, input int half);
        din  = b;
        sclk = 1'b1;
        #(half);
        sclk = 1'b0;
        #(half);
    endtask

    task automatic start_frame(input int half);
        sync = 1'b0;
        #(half);
    endtask

    task automatic send_bits(input logic [15:0] w, input int n, input int half);
        for (int i = 0; i < n; i++) begin
            if (i < 16) drive_bit(w[15-i], half);
            else        drive_bit(1'($urandom_range(0, 1)), half);
        end
    endtask

    task automatic end_frame(input int half);
        sync = 1'b1;
        #(4 * half);
    endtask

    task automatic tx_frame(input logic [15:0] w, input int nfalls, input int half);
        model_frame(w, nfalls);
        start_frame(half);
        send_bits(w, nfalls, half);
        end_frame(half);
    endtask

    task automatic align();
        @(negedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst  = 1'b1;
        sync = 1'b1;
        sclk = 1'b0;
        din  = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({bus.data_out, bus.pd_out, bus.valid, bus.frame_err, bus.busy} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs got data=%h pd=%b valid=%b err=%b busy=%b exp all 0",
                     bus.data_out, bus.pd_out, bus.valid, bus.frame_err, bus.busy);
        end
        checks++;
        if (bus.frame_cnt !== 16'd0 || bus2.frame_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d/%0d exp 0/0", bus.frame_cnt, bus2.frame_cnt);
        end
        rst = 1'b0;
        model_reset();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_single();
        int v0 = valid_seen;
        align();
        tx_frame(16'h0ABC, 16, 40);
        @(negedge clk);
        checks++;
        if (bus.data_out !== 12'hABC || bus.pd_out !== 2'b00 || bus.frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL single_frame got data=%h pd=%b cnt=%0d exp data=abc pd=00 cnt=1",
                     bus.data_out, bus.pd_out, bus.frame_cnt);
        end
        checks++;
        if (valid_seen - v0 != 1 || err_seen != 0) begin
            errors++;
            $display("FAIL single_pulses got valids=%0d errs=%0d exp 1/0", valid_seen - v0, err_seen);
        end
    endtask

    task automatic test_back_to_back();
        int v0 = valid_seen;
        align();
        tx_frame(16'h3FFF, 16, 40);
        checks++;
        if (bus.data_out !== 12'hFFF || bus.pd_out !== 2'b11) begin
            errors++;
            $display("FAIL b2b_first got data=%h pd=%b exp data=fff pd=11", bus.data_out, bus.pd_out);
        end
        tx_frame(16'hC000, 16, 40);
        @(negedge clk);
        checks++;
        if (bus.data_out !== 12'h000 || bus.pd_out !== 2'b00 || bus.frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL b2b_second got data=%h pd=%b cnt=%0d exp data=000 pd=00 cnt=%0d",
                     bus.data_out, bus.pd_out, bus.frame_cnt, exp_cnt);
        end
        checks++;
        if (valid_seen - v0 != 2) begin
            errors++;
            $display("FAIL b2b_valids got %0d exp 2", valid_seen - v0);
        end
    endtask

    task automatic test_abort();
        int v0 = valid_seen;
        int e0 = err_seen;
        align();
        model_frame(16'h0555, 10);
        start_frame(40);
        send_bits(16'h0555, 10, 40);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy got %b exp 1", bus.busy);
        end
        #1;
        end_frame(40);
        @(negedge clk);
        checks++;
        if (err_seen - e0 != 1 || valid_seen != v0) begin
            errors++;
            $display("FAIL abort_pulses got errs=%0d valids=%0d exp 1/0", err_seen - e0, valid_seen - v0);
        end
        checks++;
        if (bus.data_out !== last_data || bus.frame_cnt !== exp_cnt || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold got data=%h cnt=%0d busy=%b exp data=%h cnt=%0d busy=0",
                     bus.data_out, bus.frame_cnt, bus.busy, last_data, exp_cnt);
        end
    endtask

    task automatic test_extra_falls();
        int v0 = valid_seen;
        int e0 = err_seen;
        align();
        model_frame(16'h1234, 18);
        start_frame(40);
        send_bits(16'h1234, 18, 40);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL extra_busy got %b exp 0", bus.busy);
        end
        #1;
        end_frame(40);
        @(negedge clk);
        checks++;
        if (bus.data_out !== 12'h234 || bus.pd_out !== 2'b01 || valid_seen - v0 != 1 || err_seen != e0) begin
            errors++;
            $display("FAIL extra_falls got data=%h pd=%b valids=%0d errs=%0d exp data=234 pd=01 valids=1 errs=0",
                     bus.data_out, bus.pd_out, valid_seen - v0, err_seen - e0);
        end
    endtask

    // sync rises at the same instant as the 16th sclk fall: the frame aborts.
    task automatic test_simultaneous();
        int v0 = valid_seen;
        int e0 = err_seen;
        logic [15:0] w;
        w = 16'($urandom());
        align();
        err_exp++;
        start_frame(40);
        send_bits(w, 15, 40);
        din  = w[0];
        sclk = 1'b1;
        #40;
        sclk = 1'b0;
        sync = 1'b1;
        #160;
        @(negedge clk);
        checks++;
        if (err_seen - e0 != 1 || valid_seen != v0 || bus.data_out !== last_data) begin
            errors++;
            $display("FAIL simultaneous got errs=%0d valids=%0d data=%h exp 1/0 data=%h",
                     err_seen - e0, valid_seen - v0, bus.data_out, last_data);
        end
    endtask

    task automatic test_arm();
        int v0;
        align();
        rst  = 1'b1;
        sync = 1'b0;
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        v0 = valid_seen;
        #100;
        send_bits(16'hFFFF, 16, 40);
        #200;
        @(negedge clk);
        checks++;
        if (valid_seen != v0 || bus.frame_cnt !== 16'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL arm_ignore got valids=%0d cnt=%0d busy=%b exp 0/0/0",
                     valid_seen - v0, bus.frame_cnt, bus.busy);
        end
        #1;
        sync = 1'b1;
        #160;
        tx_frame(16'h0800, 16, 40);
        @(negedge clk);
        checks++;
        if (bus.data_out !== 12'h800 || bus.frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL arm_frame got data=%h cnt=%0d exp data=800 cnt=1", bus.data_out, bus.frame_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int e0 = err_seen;
        align();
        start_frame(40);
        send_bits(16'hA5A5, 8, 40);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.data_out, bus.pd_out, bus.valid, bus.frame_err, bus.busy, bus.frame_cnt} !== 33'd0) begin
            errors++;
            $display("FAIL midreset_zero got data=%h pd=%b valid=%b err=%b busy=%b cnt=%0d exp all 0",
                     bus.data_out, bus.pd_out, bus.valid, bus.frame_err, bus.busy, bus.frame_cnt);
        end
        #1;
        sync = 1'b1;
        #30;
        rst = 1'b0;
        model_reset();
        #160;
        tx_frame(16'h0123, 16, 40);
        @(negedge clk);
        checks++;
        if (bus.data_out !== 12'h123 || bus.frame_cnt !== 16'd1 || err_seen != e0) begin
            errors++;
            $display("FAIL midreset_frame got data=%h cnt=%0d errs=%0d exp data=123 cnt=1 errs=0",
                     bus.data_out, bus.frame_cnt, err_seen - e0);
        end
    endtask

    task automatic test_random();
        align();
        for (int k = 0; k < 12; k++) begin
            logic [15:0] w;
            int half;
            int n;
            w    = 16'($urandom());
            half = 10 * $urandom_range(3, 6);
            n    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : $urandom_range(16, 18);
            tx_frame(w, n, half);
        end
        @(negedge clk);
        checks++;
        if (err_seen != err_exp || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_totals got errs=%0d pending=%0d exp errs=%0d pending=0",
                     err_seen, exp_q.size(), err_exp);
        end
        checks++;
        if (bus.data_out !== last_data || bus.pd_out !== last_pd || bus.frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL random_final got data=%h pd=%b cnt=%0d exp data=%h pd=%b cnt=%0d",
                     bus.data_out, bus.pd_out, bus.frame_cnt, last_data, last_pd, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        align();
        do begin
            tx_frame(16'($urandom()), 16, 30);
        end while (exp_cnt[2:0] != 3'd0);
        @(negedge clk);
        checks++;
        if (bus2.frame_cnt !== 3'd0 || bus.frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL wrap got narrow=%0d wide=%0d exp narrow=0 wide=%0d",
                     bus2.frame_cnt, bus.frame_cnt, exp_cnt);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks     = 0;
        errors     = 0;
        err_exp    = 0;
        err_seen   = 0;
        valid_seen = 0;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_extra_falls();
        test_simultaneous();
        test_arm();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_serial_receiver.md
Name: dac_serial_receiver

Overview:
- Receiver end of the 3-wire DAC serial link (`sync`, `sclk`, `din`) that the signal generator drives.
- Oversamples the three wires on the system clock and deframes 16-bit MSB-first words.
- Presents the 12-bit sample and the 2 power-down bits with a one-cycle valid strobe.
- Used as an on-chip loopback checker and as a bench-side DAC model. Also counts good frames and flags aborted ones.

Parameters:
- FRAME_BITS, 16, bits per frame; the frame is committed on the FRAME_BITS-th sclk falling edge.
- DATA_BITS, 12, width of the sample field (frame bits DATA_BITS-1..0).
- SYNC_STAGES, 2, flip-flop synchronizer depth on each input wire (minimum 2).
- CNT_BITS, 16, width of the good-frame counter.

Ports:
- clk  in  1  system clock; must be at least 4x the sclk frequency.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  serial clock from the transmitter, asynchronous to clk.
- sync  in  1  active-low frame strobe, asynchronous.
- din  in  1  serial data, asynchronous; sampled on sclk falling edges.
- data_out  out  DATA_BITS  last committed sample (frame bits 11..0).
- pd_out  out  2  last committed power-down field (frame bits 13..12).
- valid  out  1  one-clk pulse when data_out/pd_out update.
- frame_err  out  1  one-clk pulse when a frame is aborted.
- busy  out  1  high while a frame is being shifted.
- frame_cnt  out  CNT_BITS  count of committed frames; wraps.

Behaviour:
- Reset values: data_out=0, pd_out=0, valid=0, frame_err=0, busy=0, frame_cnt=0; state ARM; bit counter 0; shift register 0.
- Synchronization: sclk, sync and din each pass through SYNC_STAGES flops.
- Edge detection: registered compare of the synchronized value against its previous sample. A sclk fall is prev=1, cur=0; a sync fall/rise is detected the same way.
- din is sampled from the same pipeline stage as sclk, so it stays aligned with sclk.
- Frame bits 15..14 are don't-care and are discarded.
- States:
  - ARM: wait until synchronized sync is seen high. Prevents a sync that is already low at reset release from being treated as a frame start. Then go to IDLE.
  - IDLE: on sync fall, clear the bit counter and go to SHIFT.
  - SHIFT: busy=1.
    - Each sclk fall shifts din into the LSB of the shift register and increments the bit counter.
    - When the counter reaches FRAME_BITS: on the next clk, valid=1, data_out and pd_out load from the shift register, frame_cnt increments; go to HOLD.
    - On sync rise with counter < FRAME_BITS: frame_err=1 for one clk, outputs unchanged, go to IDLE.
  - HOLD: busy=0. Extra sclk falls are ignored, with no error. On sync rise, go to IDLE.
- Latency: valid asserts SYNC_STAGES+2 clk edges after the raw 16th sclk falling edge, within ±1 clk for sampling phase.
- Simultaneous events:
  - sync rise and 16th sclk fall detected in the same clk: sync wins, the frame aborts, frame_err pulses.
  - sync fall while in HOLD: treated as rise-then-fall only if the rise was observed; otherwise ignored until a rise is seen.
- frame_cnt wraps from 2^CNT_BITS-1 to 0 silently.
- Reset mid-frame: everything returns to reset values immediately; the partial frame is lost and no frame_err pulse is generated.
- Glitch tolerance: sclk high/low phases shorter than 2 clk periods are not guaranteed to be captured. This is an input requirement, not checked.

Decomposition:
- Shared package: FRAME_BITS/DATA_BITS defaults, PD field bit positions (13..12), and the state encoding constants (ARM, IDLE, SHIFT, HOLD). The transmitter uses the same field positions.
- One sub-module, sync_edge_det: a SYNC_STAGES synchronizer plus a registered rise/fall detector.
  - Instantiated for sclk and sync.
  - din uses a plain synchronizer of equal depth for alignment.

Test Plan:
1. Reset, sync high, send word 0x0ABC at sclk = clk/8 -> one valid pulse; data_out=0xABC, pd_out=2'b00, frame_cnt=1, frame_err never high.
2. Send 0x3FFF then 0xC000 back-to-back (sync high for 2 sclk periods between) -> first valid gives data_out=0xFFF, pd_out=2'b11; second gives data_out=0x000, pd_out=2'b00; frame_cnt=2.
3. Send 10 bits of 0x0555, then raise sync -> frame_err pulses once; valid stays 0; data_out keeps its prior value; frame_cnt unchanged.
4. Send 0x1234 with 18 sclk falls before sync rises -> exactly one valid; data_out=0x234, pd_out=2'b01; the extra edges are ignored and produce no error.
5. Hold sync low through reset release, then clock 16 bits -> no valid (ARM state); after sync goes high then low, a new frame of 0x0800 gives data_out=0x800.
6. Assert rst after 8 bits of a frame, release, then send 0x0123 -> all outputs read 0 during reset; afterwards data_out=0x123 and frame_cnt=1. Preload the counter to 0xFFFF with 65535 frames (or a force) plus one more frame -> frame_cnt wraps to 0.
